dm_port_ctrl: RTL and testbench
===============================

// Module: dm_port_ctrl
// PURPOSE
//  Two-port access controller in front of the byte-addressed data memory (dm: 12-bit addr,
//  32-bit little-endian word, combinational read, posedge write when we=1). Arbitrates between
//  port 0 (CPU load/store unit) and port 1 (debug/DMA loader) with round-robin priority. Turns
//  byte-enable stores (sb/sh) into read-modify-write, since dm only writes whole words.
// PARAMETERS
//  AW        12    byte address width (matches dm addr)
//  DW        32    data width; fixed 32 (4 byte lanes)
//  DEPTH     1024  dm size in bytes; word addr >= DEPTH-3 is out of range
//  FIXED_PRI 0     1 = port 0 always wins; 0 = round-robin
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    asynchronous active-low reset
//  pN_req    in   1    port N (N=0,1) request; held stable with its fields until pN_ack
//  pN_we     in   1    1 = store, 0 = load
//  pN_addr   in   AW   byte address; [1:0] ignored (word aligned)
//  pN_be     in   4    store byte enables, bit i = byte lane i (din[8i+7:8i])
//  pN_wdata  in   DW   store data
//  pN_ack    out  1    one-cycle completion pulse
//  pN_err    out  1    valid with pN_ack: address out of range
//  pN_rdata  out  DW   load data, valid with pN_ack and held until next ack on that port
//  dm_addr   out  AW   to dm addr
//  dm_din    out  DW   to dm din
//  dm_we     out  1    to dm we
//  dm_dout   in   DW   from dm dout
//  busy      out  1    1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, rr pointer=0 (port 0 favoured), all acks/errs=0,
//    rdata regs=0, dm_we=0, dm_addr=0, dm_din=0. Reset mid-operation aborts: no dm write may
//    occur after rst_n falls; an aborted request gets no ack and must be re-issued.
//  - FSM: IDLE -> ACC -> [MRG] -> RESP -> IDLE.
//    IDLE: if any req, pick winner, latch port id/we/addr{[AW-1:2],2'b00}/be/wdata, go ACC.
//          Both req: winner = rr pointer (FIXED_PRI=1: port 0). Pointer flips to the other
//          port after each grant.
//    ACC:  dm_addr=latched addr. Out of range -> err, no write, rdata=0. Load: capture
//          dm_dout into winner's rdata. Store be=4'hF: dm_we=1, dm_din=wdata. Store be=0:
//          no write. Partial store: capture dm_dout into merge reg, go MRG. Else go RESP.
//    MRG:  dm_din = per-lane mux (be[i] ? wdata lane : merge lane), dm_we=1, go RESP.
//    RESP: winner's ack=1 for exactly this cycle (err as computed), go IDLE.
//  - dm_we is decoded from the registered state only, so it is glitch-free and drops with reset.
//  - Latency (req seen in IDLE at cycle 0): load / full store / be=0 / err: ack in cycle 2.
//    Partial store: ack in cycle 3. Back-to-back: next grant earliest the cycle after RESP.
//  - Requester drops req in the cycle after ack. A req still high during RESP is not re-granted
//    (controller is not in IDLE). The loser of an arbitration keeps req high and is served next.
//  - dm_addr, dm_din hold their last value outside ACC/MRG. Only dm_we qualifies a write.
//  - Never two acks in one cycle. Never an ack without a preceding grant.
// TESTING
//  1 p0 store addr=0x010 be=F wdata=0xDEADBEEF, then p0 load 0x010 -> one dm_we pulse,
//    ack at cycle 2 for each, rdata=0xDEADBEEF.
//  2 Preload 0x020=0x11223344; p1 store be=4'b0010 wdata=0x0000AA00 -> ack at cycle 3,
//    word=0x1122AA44. Then be=4'b1100 wdata=0x55660000 -> 0x55660000|0xAA44 = 0x5566AA44.
//  3 p0 and p1 both req loads from reset -> p0 acked first, p1 next. Repeat with both req ->
//    p1 first. FIXED_PRI=1 -> p0 first both times.
//  4 p0 store addr=0x3FE (>= DEPTH-3) -> ack with err=1, no dm_we, memory unchanged.
//    Store be=0 -> ack, no dm_we.
//  5 Assert rst_n=0 during MRG of a partial store -> dm_we=0 immediately, no ack, busy=0,
//    memory word unchanged. After release, the re-issued request completes normally.
//  6 p1 holds req through a 20-transaction p0 stream under round-robin -> p1 served within
//    one p0 transaction. Never two acks in one cycle.

Source files
------------

// File: rtl/dm_port_ctrl_if.sv
// dm_port_ctrl_if: one requester port of the data-memory controller.
// The master is the requester; the slave is the controller.
interface dm_port_ctrl_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;
  modport master (output req, we, addr, be, wdata, input ack, err, rdata);
  modport slave (input req, we, addr, be, wdata, output ack, err, rdata);
endinterface

// File: rtl/dm_port_ctrl.sv
// dm_port_ctrl: two-port arbiter in front of the word-wide data memory.
// Partial stores are done as read-modify-write.
module dm_port_ctrl #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int DEPTH     = 1024,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_port_ctrl_if.slave p0,
  dm_port_ctrl_if.slave p1,
  output logic [AW-1:0] dm_addr_o,
  output logic [DW-1:0] dm_din_o,
  output logic          dm_we_o,
  input  logic [DW-1:0] dm_dout_i,
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, ACC, MRG, RESP} state_e;
  state_e        state_q, state_d;
  logic          rr_q, id_q, we_q, err_q;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q, rd0_q, rd1_q;
  logic          grant, win, req_err, full, partial;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] mask;
  assign grant    = p0.req | p1.req;
  assign win      = (p0.req & p1.req) ? (FIXED_PRI ? 1'b0 : rr_q) : p1.req;
  assign req_addr = win ? p1.addr : p0.addr;
  // range check uses the raw byte address, before word alignment
  assign req_err  = 32'(req_addr) >= 32'(DEPTH - 3);
  assign full     = be_q == 4'hF;
  assign partial  = we_q & ~err_q & (be_q != 4'h0) & ~full;
  assign mask     = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (grant ? ACC : IDLE) :
              state_q == ACC  ? (partial ? MRG : RESP) :
              state_q == MRG  ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= '0;
      din_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant) begin
        id_q   <= win;
        rr_q   <= ~win;
        we_q   <= win ? p1.we : p0.we;
        be_q   <= win ? p1.be : p0.be;
        err_q  <= req_err;
        addr_q <= {req_addr[AW-1:2], 2'b00};
        din_q  <= win ? p1.wdata : p0.wdata;
      end
      if (state_q == ACC && (err_q || !we_q)) begin
        if (id_q) rd1_q <= err_q ? '0 : dm_dout_i;
        else      rd0_q <= err_q ? '0 : dm_dout_i;
      end
      // merge keeps enabled store lanes and refills the rest from memory
      if (state_q == ACC && partial) din_q <= (din_q & mask) | (dm_dout_i & ~mask);
    end
  end
  assign dm_addr_o = addr_q;
  assign dm_din_o  = din_q;
  assign dm_we_o   = (state_q == ACC && we_q && !err_q && full) || state_q == MRG;
  assign busy_o    = state_q != IDLE;
  assign p0.ack    = state_q == RESP && !id_q;
  assign p1.ack    = state_q == RESP && id_q;
  assign p0.err    = p0.ack & err_q;
  assign p1.err    = p1.ack & err_q;
  assign p0.rdata  = rd0_q;
  assign p1.rdata  = rd1_q;
endmodule

// File: tb/tb_dm_port_ctrl.sv
// tb_dm_port_ctrl: directed checks of arbitration, latency, read-modify-write,
// range errors and reset abort against a behavioural data memory.
module tb_dm_port_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] dm_addr, fx_addr;
  logic [31:0] dm_din, dm_dout, fx_din, fx_dout;
  logic        dm_we, busy, fx_we, fx_busy;
  logic [31:0] mem [256];
  int          we_cnt = 0;
  int          dual = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          l0, l1, w0, pre, first;
  logic        e0, e1, p1_done;
  logic [31:0] r0, r1;
  always #5 clk = ~clk;
  dm_port_ctrl_if p0_if ();
  dm_port_ctrl_if p1_if ();
  dm_port_ctrl_if f0_if ();
  dm_port_ctrl_if f1_if ();
  dm_port_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .p0(p0_if), .p1(p1_if),
    .dm_addr_o(dm_addr), .dm_din_o(dm_din), .dm_we_o(dm_we),
    .dm_dout_i(dm_dout), .busy_o(busy)
  );
  dm_port_ctrl #(.FIXED_PRI(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n), .p0(f0_if), .p1(f1_if),
    .dm_addr_o(fx_addr), .dm_din_o(fx_din), .dm_we_o(fx_we),
    .dm_dout_i(fx_dout), .busy_o(fx_busy)
  );
  assign dm_dout = mem[dm_addr[9:2]];
  assign fx_dout = mem[fx_addr[9:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;
  always @(posedge clk) if (dm_we) we_cnt <= we_cnt + 1;
  always @(negedge clk) if ((p0_if.ack && p1_if.ack) || (f0_if.ack && f1_if.ack)) dual <= dual + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns cycles to ack (50 = timed out) and the response
  task automatic xact(input bit port, input bit we, input logic [11:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, output int lat, output logic err, output logic [31:0] rdata);
    logic ack = 1'b0;
    if (port) begin
      p1_if.we = we; p1_if.addr = addr; p1_if.be = be; p1_if.wdata = wdata; p1_if.req = 1'b1;
    end else begin
      p0_if.we = we; p0_if.addr = addr; p0_if.be = be; p0_if.wdata = wdata; p0_if.req = 1'b1;
    end
    lat = 0;
    while (!ack && lat < 50) begin
      @(negedge clk);
      lat++;
      ack = port ? p1_if.ack : p0_if.ack;
    end
    err   = port ? p1_if.err : p0_if.err;
    rdata = port ? p1_if.rdata : p0_if.rdata;
    if (port) p1_if.req = 1'b0;
    else      p0_if.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic fix_round(output int who);
    who = -1;
    f0_if.req = 1'b1;
    f1_if.req = 1'b1;
    for (int c = 0; c < 20 && (f0_if.req || f1_if.req); c++) begin
      @(negedge clk);
      if (f0_if.ack) begin f0_if.req = 1'b0; if (who < 0) who = 0; end
      if (f1_if.ack) begin f1_if.req = 1'b0; if (who < 0) who = 1; end
    end
    f0_if.req = 1'b0;
    f1_if.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    p0_if.req = 0; p0_if.we = 0; p0_if.addr = '0; p0_if.be = '0; p0_if.wdata = '0;
    p1_if.req = 0; p1_if.we = 0; p1_if.addr = '0; p1_if.be = '0; p1_if.wdata = '0;
    f0_if.req = 0; f0_if.we = 0; f0_if.addr = 12'h010; f0_if.be = '0; f0_if.wdata = '0;
    f1_if.req = 0; f1_if.we = 0; f1_if.addr = 12'h020; f1_if.be = '0; f1_if.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_din", dm_din, 0);
    chk("rst_acks", {p0_if.ack, p1_if.ack}, 0);
    chk("rst_rdata", p0_if.rdata | p1_if.rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // round robin: contended from reset, then after one lone p0 grant
    mem[4] = 32'h0A0A0A0A;
    mem[8] = 32'h0B0B0B0B;
    fork
      xact(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, l0, e0, r0);
      xact(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, l1, e1, r1);
    join
    chk("rr_a_p0_lat", l0, 2);
    chk("rr_a_p1_lat", l1, 5);
    chk("rr_a_p0_rd", r0, 32'h0A0A0A0A);
    chk("rr_a_p1_rd", r1, 32'h0B0B0B0B);
    xact(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, l0, e0, r0);
    chk("rr_lone_lat", l0, 2);
    fork
      xact(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, l0, e0, r0);
      xact(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, l1, e1, r1);
    join
    chk("rr_b_p1_lat", l1, 2);
    chk("rr_b_p0_lat", l0, 5);
    fix_round(first);
    chk("fix_a_first", first, 0);
    fix_round(first);
    chk("fix_b_first", first, 0);
    chk("fix_rd0", f0_if.rdata, 32'h0A0A0A0A);
    chk("fix_rd1", f1_if.rdata, 32'h0B0B0B0B);
    chk("fix_we", fx_we, 0);
    chk("fix_din", fx_din, 0);
    chk("fix_busy", fx_busy, 0);
    // full store then load
    w0 = we_cnt;
    xact(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, l0, e0, r0);
    chk("st_lat", l0, 2);
    chk("st_err", e0, 0);
    chk("st_we_pulses", we_cnt - w0, 1);
    chk("st_mem", mem[4], 32'hDEADBEEF);
    xact(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, l0, e0, r0);
    chk("ld_lat", l0, 2);
    chk("ld_rdata", r0, 32'hDEADBEEF);
    // out of range, in-range boundary, empty byte enable
    mem[255] = 32'hA5A5A5A5;
    w0 = we_cnt;
    xact(1'b0, 1'b1, 12'h3FE, 4'hF, 32'h12345678, l0, e0, r0);
    chk("oor_lat", l0, 2);
    chk("oor_err", e0, 1);
    chk("oor_rdata", r0, 0);
    chk("oor_we", we_cnt - w0, 0);
    chk("oor_mem", mem[255], 32'hA5A5A5A5);
    xact(1'b0, 1'b0, 12'h3FC, 4'h0, 32'h0, l0, e0, r0);
    chk("edge_err", e0, 0);
    chk("edge_rdata", r0, 32'hA5A5A5A5);
    w0 = we_cnt;
    xact(1'b0, 1'b1, 12'h010, 4'h0, 32'h0, l0, e0, r0);
    chk("be0_lat", l0, 2);
    chk("be0_err", e0, 0);
    chk("be0_we", we_cnt - w0, 0);
    chk("be0_mem", mem[4], 32'hDEADBEEF);
    // partial stores on port 1
    mem[8] = 32'h11223344;
    w0 = we_cnt;
    xact(1'b1, 1'b1, 12'h020, 4'b0010, 32'h0000AA00, l1, e1, r1);
    chk("rmw1_lat", l1, 3);
    chk("rmw1_mem", mem[8], 32'h1122AA44);
    chk("rmw1_we", we_cnt - w0, 1);
    xact(1'b1, 1'b1, 12'h023, 4'b1100, 32'h55660000, l1, e1, r1);
    chk("rmw2_lat", l1, 3);
    chk("rmw2_mem", mem[8], 32'h5566AA44);
    xact(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, l1, e1, r1);
    chk("rmw_ld", r1, 32'h5566AA44);
    // reset during the merge cycle of a partial store
    mem[16] = 32'hCAFEF00D;
    p0_if.we = 1'b1; p0_if.addr = 12'h040; p0_if.be = 4'b0001; p0_if.wdata = 32'h000000FF;
    p0_if.req = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_pre_we", dm_we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", dm_we, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("abort_ack", p0_if.ack, 0);
    p0_if.req = 1'b0;
    chk("abort_mem", mem[16], 32'hCAFEF00D);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 1'b1, 12'h040, 4'b0001, 32'h000000FF, l0, e0, r0);
    chk("reissue_lat", l0, 3);
    chk("reissue_mem", mem[16], 32'hCAFEF0FF);
    // p1 must not starve behind a p0 stream
    pre = 0;
    p1_done = 1'b0;
    fork
      for (int k = 0; k < 20; k++) begin
        xact(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, l0, e0, r0);
        if (!p1_done) pre++;
      end
      begin
        @(negedge clk);
        xact(1'b1, 1'b0, 12'h040, 4'h0, 32'h0, l1, e1, r1);
        p1_done = 1'b1;
      end
    join
    chk("stream_p1_wait", pre <= 1, 1);
    chk("stream_p1_rd", r1, 32'hCAFEF0FF);
    chk("stream_p0_rd", r0, 32'hDEADBEEF);
    chk("dual_ack", dual, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
